alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Registered output stage placed directly downstream of the 32-bit arithmetic/shift ALU. It captures each ALU result and its four status flags through a valid/ready handshake. A two-entry skid buffer keeps full throughput while presenting fully registered outputs to the writeback consumer. It also keeps sticky status flags and a saturating count of accepted operations for debug and status readout.

## Interface
- `WIDTH`, 32, data width of the ALU result.
- `CNT_W`, 16, width of the accepted-operation counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU result and flags valid this cycle.
- `in_ready`  out  1  buffer can accept; transfer occurs when `in_valid & in_ready`.
- `in_result`  in  WIDTH  ALU result.
- `in_flags`  in  4  bit order {carry, zero, overflow, sign} = [3:0].
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts; pop occurs when `out_valid & out_ready`.
- `out_result`  out  WIDTH  buffered result.
- `out_flags`  out  4  buffered flags, same bit order as `in_flags`.
- `clr_stats`  in  1  synchronous clear of `sticky_flags` and `op_count`.
- `sticky_flags`  out  4  OR of the flags of all words accepted since the last clear.
- `op_count`  out  CNT_W  number of words accepted, saturating at all-ones.

## Operation
- Storage is a main register (drives `out_*`) and a skid register, plus state EMPTY / ONE / FULL.
- `out_valid` = (state != EMPTY). `in_ready` = (state != FULL). Both are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- State transitions (acc = accept, pop as defined above):
  - EMPTY, acc: load main, go to ONE.
  - ONE, acc & pop: load main with the new word, stay in ONE.
  - ONE, acc & !pop: load skid, go to FULL.
  - ONE, !acc & pop: go to EMPTY.
  - FULL (acc impossible), pop: main <= skid, go to ONE.
  - No event in any state: hold.
- Order is strictly preserved. No word is dropped or duplicated.
- Data registers load only on the events listed above and otherwise hold. Contents while EMPTY are don't-care for checking but are held stable.
- `sticky_flags`:
  - On acc: `sticky <= sticky | in_flags`.
  - On `clr_stats` with acc in the same cycle: `sticky <= in_flags`.
  - On `clr_stats` alone: `sticky <= 0`.
- `op_count`:
  - On acc: +1, saturating at 2^CNT_W-1 (no wrap).
  - On `clr_stats` with acc in the same cycle: `op_count <= 1`.
  - On `clr_stats` alone: `op_count <= 0`.
- Flags are not reinterpreted: the buffer passes through exactly what the ALU drove, including zero/sign.

## Timing
- Reset (async assert, synchronous-safe deassert is the integrator's duty):
  - state EMPTY.
  - `out_valid`=0, `in_ready`=1.
  - `out_result`=0, `out_flags`=0, `sticky_flags`=0, `op_count`=0.
- Latency: a word accepted at edge N appears on `out_*` with `out_valid`=1 after edge N when the buffer was EMPTY, or once the words ahead of it pop.
- Throughput: one word per cycle sustained while `out_ready`=1.
- `in_ready` falls the cycle after a stalled acceptance fills the skid. It rises the cycle after a pop from FULL.
- Reset mid-operation discards both entries immediately. No partial output follows deassertion.
- Handshake rules for upstream: `in_*` may change freely when `in_valid`=0. No requirement is placed on upstream holding data while `in_ready`=0, because no transfer occurs.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset, then one word: hold `rst_n` low, then push `in_result`=0x0000_0005 with flags 4'b0000 and `out_ready`=1. Required: `out_valid` the next cycle with 0x5, `op_count`=1, `sticky_flags`=0.
- Back-to-back stream: 8 consecutive words 1..8 with `out_ready`=1. Required: output 1..8 on consecutive cycles, `in_ready` constantly 1, `op_count`=8.
- Stall and fill: `out_ready`=0 and push words A=0xAAAA_0001 and B=0xBBBB_0002. Required: `in_ready`=0 after B; a third word C is not accepted. Raise `out_ready`: output is A, B, then C in order, with `op_count`=3.
- Sticky flags and clear: accept flags 4'b1000, then 4'b0010. Required: `sticky_flags`=4'b1010. Then assert `clr_stats` together with an accept of flags 4'b0001. Required: `sticky_flags`=4'b0001 and `op_count`=1.
- Counter saturation (CNT_W=4): accept 20 words. Required: `op_count` stops at 15.
- Reset mid-stall: in FULL state, pulse `rst_n` low asynchronously. Required: `out_valid`=0 and `in_ready`=1 immediately, counters 0, and no stale word emitted afterwards.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//
// Registered output stage for the 32-bit ALU. Each ALU result and its four
// status flags are captured through a valid/ready handshake into a two-entry
// skid buffer. The writeback consumer sees fully registered outputs, and full
// throughput is kept because the skid entry absorbs the one word that may
// arrive in the cycle the consumer stalls. Sticky status flags and a
// saturating count of accepted words are kept for debug readout.
//
// Ports:
//   clk, rst_n     single clock, asynchronous active-low reset
//   in_valid       ALU word valid this cycle
//   in_ready       buffer can accept (decoded from registered state only)
//   in_result      ALU result, WIDTH bits
//   in_flags       {carry, zero, overflow, sign}
//   out_valid      output word valid (decoded from registered state only)
//   out_ready      consumer accepts the output word
//   out_result     buffered result
//   out_flags      buffered flags, same order as in_flags
//   clr_stats      synchronous clear of sticky_flags and op_count
//   sticky_flags   OR of flags of all words accepted since the last clear
//   op_count       accepted word count, saturating at all-ones

module alu_result_buffer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   input  logic             clr_stats,
   output logic [3:0]       sticky_flags,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] main_result;
   logic [3:0]       main_flags;
   logic [WIDTH-1:0] skid_result;
   logic [3:0]       skid_flags;
   logic             acc;
   logic             pop;
   logic             load_main;
   logic             load_skid;
   logic             move_skid;

   // Handshake outputs depend only on the registered state, so neither
   // in_ready nor out_valid has a combinational path from the other side.
   assign in_ready   = (state_q != FULL);
   assign out_valid  = (state_q != EMPTY);
   assign acc        = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign out_result = main_result;
   assign out_flags  = main_flags;

   // Next-state and data-move decode. The main register always holds the
   // oldest word; the skid register only ever holds the word that arrived
   // while the consumer was stalled with main already occupied.
   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (acc) begin
               load_main = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (acc && pop) begin
               load_main = 1'b1;
            end else if (acc) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (pop) begin
               state_d   = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               move_skid = 1'b1;
               state_d   = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State register; reset discards both entries at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Data registers load only on the decoded events and otherwise hold,
   // which keeps out_* stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_result <= '0;
         main_flags  <= '0;
         skid_result <= '0;
         skid_flags  <= '0;
      end else begin
         if (load_main) begin
            main_result <= in_result;
            main_flags  <= in_flags;
         end else if (move_skid) begin
            main_result <= skid_result;
            main_flags  <= skid_flags;
         end
         if (load_skid) begin
            skid_result <= in_result;
            skid_flags  <= in_flags;
         end
      end
   end

   // Statistics. A clear in the same cycle as an accept restarts the
   // statistics with that word counted rather than losing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_flags <= '0;
         op_count     <= '0;
      end else if (clr_stats) begin
         if (acc) begin
            sticky_flags <= in_flags;
            op_count     <= CNT_ONE;
         end else begin
            sticky_flags <= '0;
            op_count     <= '0;
         end
      end else if (acc) begin
         sticky_flags <= sticky_flags | in_flags;
         if (op_count != CNT_MAX) begin
            op_count <= op_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer
//
// Directed bench for alu_result_buffer. Two instances share all inputs: the
// default-width instance and one with a 4-bit counter used for the
// saturation check. Inputs change 1 ns after each rising edge and outputs
// are sampled at that same point, away from the active edge.

module tb_alu_result_buffer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [3:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   logic        clr_stats;
   logic [3:0]  sticky_flags;
   logic [15:0] op_count;

   logic        sat_in_ready;
   logic        sat_out_valid;
   logic [31:0] sat_out_result;
   logic [3:0]  sat_out_flags;
   logic [3:0]  sat_sticky_flags;
   logic [3:0]  sat_op_count;

   int assertionCount = 0;
   int failCount      = 0;

   alu_result_buffer #(.WIDTH(32), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .clr_stats    (clr_stats),
      .sticky_flags (sticky_flags),
      .op_count     (op_count)
   );

   alu_result_buffer #(.WIDTH(32), .CNT_W(4)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (sat_in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .out_valid    (sat_out_valid),
      .out_ready    (out_ready),
      .out_result   (sat_out_result),
      .out_flags    (sat_out_flags),
      .clr_stats    (clr_stats),
      .sticky_flags (sat_sticky_flags),
      .op_count     (sat_op_count)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertionCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] result,
                                input logic [3:0] flags, input logic ready,
                                input logic clr);
      in_valid  = valid;
      in_result = result;
      in_flags  = flags;
      out_ready = ready;
      clr_stats = clr;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      // Reset state
      stepCycle();
      stepCycle();
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset out_result", out_result, 32'd0);
      checkOutput("reset out_flags", {28'b0, out_flags}, 32'd0);
      checkOutput("reset sticky", {28'b0, sticky_flags}, 32'd0);
      checkOutput("reset op_count", {16'b0, op_count}, 32'd0);
      rst_n = 1'b1;
      stepCycle();

      // Single word after reset
      $display("[TB] single word");
      applyStimulus(1'b1, 32'h0000_0005, 4'b0000, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("single out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("single out_result", out_result, 32'h5);
      checkOutput("single op_count", {16'b0, op_count}, 32'd1);
      checkOutput("single sticky", {28'b0, sticky_flags}, 32'd0);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("single drained", {31'b0, out_valid}, 32'd0);
      checkOutput("clear alone op_count", {16'b0, op_count}, 32'd0);

      // Back-to-back stream of 1..8
      $display("[TB] stream");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, i, i[3:0], 1'b1, 1'b0);
         checkOutput($sformatf("stream in_ready %0d", i), {31'b0, in_ready}, 32'd1);
         stepCycle();
         checkOutput($sformatf("stream valid %0d", i), {31'b0, out_valid}, 32'd1);
         checkOutput($sformatf("stream result %0d", i), out_result, i);
         checkOutput($sformatf("stream flags %0d", i), {28'b0, out_flags}, i & 32'hF);
      end
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("stream op_count", {16'b0, op_count}, 32'd8);
      checkOutput("stream sat result", sat_out_result, 32'd8);
      stepCycle();
      checkOutput("stream drained", {31'b0, out_valid}, 32'd0);

      // Stall and fill
      $display("[TB] stall and fill");
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 32'hAAAA_0001, 4'b0100, 1'b0, 1'b0);
      stepCycle();
      checkOutput("fill after A in_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'hBBBB_0002, 4'b0011, 1'b0, 1'b0);
      stepCycle();
      checkOutput("fill after B in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("fill head is A", out_result, 32'hAAAA_0001);
      applyStimulus(1'b1, 32'hCCCC_0003, 4'b1001, 1'b0, 1'b0);
      stepCycle();
      checkOutput("C refused in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stalled head A", out_result, 32'hAAAA_0001);
      checkOutput("stalled flags A", {28'b0, out_flags}, 32'h4);
      checkOutput("C refused op_count", {16'b0, op_count}, 32'd2);
      applyStimulus(1'b1, 32'hCCCC_0003, 4'b1001, 1'b1, 1'b0);
      stepCycle();
      checkOutput("drain second is B", out_result, 32'hBBBB_0002);
      checkOutput("drain flags B", {28'b0, out_flags}, 32'h3);
      checkOutput("in_ready back", {31'b0, in_ready}, 32'd1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("drain third is C", out_result, 32'hCCCC_0003);
      checkOutput("drain flags C", {28'b0, out_flags}, 32'h9);
      checkOutput("fill op_count", {16'b0, op_count}, 32'd3);
      stepCycle();
      checkOutput("fill drained", {31'b0, out_valid}, 32'd0);

      // Sticky flags and clear
      $display("[TB] sticky flags");
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
      stepCycle();
      checkOutput("sticky cleared", {28'b0, sticky_flags}, 32'd0);
      applyStimulus(1'b1, 32'h10, 4'b1000, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h20, 4'b0010, 1'b1, 1'b0);
      stepCycle();
      checkOutput("sticky accumulate", {28'b0, sticky_flags}, 32'hA);
      applyStimulus(1'b1, 32'h30, 4'b0001, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("clear with accept sticky", {28'b0, sticky_flags}, 32'h1);
      checkOutput("clear with accept op_count", {16'b0, op_count}, 32'd1);
      checkOutput("clear with accept sat cnt", {28'b0, sat_op_count}, 32'd1);
      stepCycle();

      // Counter saturation on the 4-bit instance
      $display("[TB] counter saturation");
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
      stepCycle();
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 32'h100 + i, 4'h0, 1'b1, 1'b0);
         stepCycle();
         if (i == 15) begin
            checkOutput("sat reaches max", {28'b0, sat_op_count}, 32'd15);
         end
      end
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("sat held at max", {28'b0, sat_op_count}, 32'd15);
      checkOutput("wide counter 20", {16'b0, op_count}, 32'd20);
      stepCycle();

      // Reset while full
      $display("[TB] reset mid-stall");
      applyStimulus(1'b1, 32'hDEAD_0001, 4'b0110, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'hDEAD_0002, 4'b0101, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("pre-reset full", {31'b0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("async op_count", {16'b0, op_count}, 32'd0);
      checkOutput("async sticky", {28'b0, sticky_flags}, 32'd0);
      checkOutput("async out_result", out_result, 32'd0);
      stepCycle();
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput($sformatf("no stale word %0d", i), {31'b0, out_valid}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertionCount, failCount);
      $finish;
   end

endmodule
